// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: key codes, FSM encoding and
// the key-code to (row, column) matrix decode.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BOUNCE  = 2'd1,
        ST_PRESS   = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] row_n;
        logic [2:0] col_n;
    } key_pos_t;

    // Both patterns are active-low one-hot; an invalid code yields all-high.
    function automatic key_pos_t key_decode(input logic [3:0] code);
        key_pos_t   pos;
        logic [1:0] r;
        logic [1:0] c;
        pos.valid = 1'b1;
        r = 2'd0;
        c = 2'd0;
        case (code)
            4'h1:     begin r = 2'd0; c = 2'd0; end
            4'h2:     begin r = 2'd0; c = 2'd1; end
            4'h3:     begin r = 2'd0; c = 2'd2; end
            4'h4:     begin r = 2'd1; c = 2'd0; end
            4'h5:     begin r = 2'd1; c = 2'd1; end
            4'h6:     begin r = 2'd1; c = 2'd2; end
            4'h7:     begin r = 2'd2; c = 2'd0; end
            4'h8:     begin r = 2'd2; c = 2'd1; end
            4'h9:     begin r = 2'd2; c = 2'd2; end
            KEY_STAR: begin r = 2'd3; c = 2'd0; end
            4'h0:     begin r = 2'd3; c = 2'd1; end
            KEY_HASH: begin r = 2'd3; c = 2'd2; end
            default:  pos.valid = 1'b0;
        endcase
        if (pos.valid) begin
            pos.row_n = ~(4'b0001 << r);
            pos.col_n = ~(3'b001 << c);
        end else begin
            pos.row_n = 4'b1111;
            pos.col_n = 3'b111;
        end
        return pos;
    endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// Combinational key-code decode into active-low row/column patterns.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [3:0] key_code,
    output logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic       valid
);

    key_pos_t pos_s;

    assign pos_s = key_decode(key_code);
    assign col_n = pos_s.col_n;
    assign row_n = pos_s.row_n;
    assign valid = pos_s.valid;

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one key of a 3x4 matrix keypad being pressed, bounced and
// released, answering the scanner's column strobes on the row lines.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_SCANS    = 4,
    parameter int BOUNCE_SCANS  = 0,
    parameter int RELEASE_SCANS = 2,
    parameter int TIMEOUT_CYC   = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       press_req,
    input  logic [2:0] column,
    output logic [3:0] row,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e      state_q, state_d;
    logic [2:0]  key_col_q, key_col_d;
    logic [3:0]  key_row_q, key_row_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] wd_q, wd_d;
    logic [2:0]  col_q, col_prev_q;
    logic [3:0]  row_q, row_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [2:0]  dec_col_n_s;
    logic [3:0]  dec_row_n_s;
    logic        dec_valid_s;
    logic        scan_ev_s;
    logic        key_on_s;
    logic [3:0]  cnt_inc_s;
    logic [15:0] wd_inc_s;
    logic [3:0]  limit_s;

    keypad_key_decode u_decode (
        .key_code (key_code),
        .col_n    (dec_col_n_s),
        .row_n    (dec_row_n_s),
        .valid    (dec_valid_s)
    );

    always_comb begin
        state_d   = state_q;
        key_col_d = key_col_q;
        key_row_d = key_row_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // One event per scan: the latched key's column line going low.
        scan_ev_s = |(col_prev_q & ~col_q & ~key_col_q);
        key_on_s  = (state_q == ST_PRESS) || ((state_q == ST_BOUNCE) && !cnt_q[0]);
        row_d     = (key_on_s && (column == key_col_q)) ? key_row_q : 4'b1111;
        cnt_inc_s = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        wd_inc_s  = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;

        case (state_q)
            ST_BOUNCE: limit_s = 4'(BOUNCE_SCANS);
            ST_PRESS:  limit_s = 4'(HOLD_SCANS);
            default:   limit_s = 4'(RELEASE_SCANS);
        endcase

        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                wd_d  = 16'd0;
                if (press_req && dec_valid_s) begin
                    key_col_d = dec_col_n_s;
                    key_row_d = dec_row_n_s;
                    busy_d    = 1'b1;
                    state_d   = (BOUNCE_SCANS == 0) ? ST_PRESS : ST_BOUNCE;
                end else if (press_req) begin
                    err_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_BOUNCE, ST_PRESS, ST_RELEASE: begin
                if (scan_ev_s) begin
                    wd_d  = 16'd0;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == limit_s) begin
                        cnt_d = 4'd0;
                        case (state_q)
                            ST_BOUNCE: state_d = ST_PRESS;
                            ST_PRESS:  state_d = ST_RELEASE;
                            default: begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    wd_d = wd_inc_s;
                    if (wd_inc_s == 16'(TIMEOUT_CYC)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        row_d   = 4'b1111;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset forces the rows open immediately, even mid-press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_col_q  <= 3'b111;
            key_row_q  <= 4'b1111;
            cnt_q      <= 4'd0;
            wd_q       <= 16'd0;
            col_q      <= 3'b111;
            col_prev_q <= 3'b111;
            row_q      <= 4'b1111;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_col_q  <= key_col_d;
            key_row_q  <= key_row_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            col_q      <= column;
            col_prev_q <= col_q;
            row_q      <= row_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign row  = row_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: randomized scanner stimulus against a press
// model that counts key-column scans since the accepted request.
module tb_keypad_emulator;
    import keypad_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_code;
    logic       req_a, req_b;
    logic [2:0] column;
    logic [3:0] row_a, row_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;
    int sel   = 0;

    bit         m_act = 1'b0;
    int         m_key = 0;
    int         m_n   = 0;
    int         m_wd  = 0;
    logic [2:0] m_s1  = 3'b111;
    logic [2:0] m_s2  = 3'b111;

    always #5 clk = ~clk;

    keypad_emulator dut_a (
        .clk (clk), .rst (rst), .key_code (key_code), .press_req (req_a),
        .column (column), .row (row_a), .busy (busy_a), .done (done_a), .err (err_a)
    );

    keypad_emulator #(.BOUNCE_SCANS(3)) dut_b (
        .clk (clk), .rst (rst), .key_code (key_code), .press_req (req_b),
        .column (column), .row (row_b), .busy (busy_b), .done (done_b), .err (err_b)
    );

    function automatic int krow(input int k);
        if (k == 0 || k >= 10) return 3;
        return (k - 1) / 3;
    endfunction

    function automatic int kcol(input int k);
        if (k == 0) return 1;
        if (k == 10) return 0;
        if (k == 11) return 2;
        return (k - 1) % 3;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model predicts what the outputs show after it.
    task automatic cyc(input logic [2:0] c, input bit rq, input logic [3:0] kc);
        int         nb = (sel != 0) ? 3 : 0;
        int         kcl;
        logic [2:0] cpat;
        logic [3:0] erow = 4'hF;
        bit         edone = 1'b0;
        bit         eerr = 1'b0;
        bit         on;
        column   = c;
        key_code = kc;
        req_a    = rq && (sel == 0);
        req_b    = rq && (sel != 0);
        if (m_act) begin
            kcl  = kcol(m_key);
            cpat = 3'b111;
            cpat[kcl] = 1'b0;
            on = (m_n < nb) ? (m_n % 2 == 0) : (m_n < nb + 4);
            if (on && c == cpat) begin
                erow = 4'hF;
                erow[krow(m_key)] = 1'b0;
            end
            if (m_s2[kcl] && !m_s1[kcl]) begin
                m_n++;
                m_wd = 0;
                if (m_n == nb + 4 + 2) begin
                    edone = 1'b1;
                    m_act = 1'b0;
                end
            end else begin
                m_wd++;
                if (m_wd == 65535) begin
                    eerr  = 1'b1;
                    erow  = 4'hF;
                    m_act = 1'b0;
                end
            end
        end else if (rq) begin
            if (kc <= KEY_HASH) begin
                m_act = 1'b1;
                m_key = int'(kc);
                m_n   = 0;
                m_wd  = 0;
            end else begin
                eerr = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = c;
        @(posedge clk);
        #1;
        check("row",  (sel != 0) ? row_b : row_a, erow);
        check("busy", {3'b000, (sel != 0) ? busy_b : busy_a}, {3'b000, m_act});
        check("done", {3'b000, (sel != 0) ? done_b : done_a}, {3'b000, edone});
        check("err",  {3'b000, (sel != 0) ? err_b : err_a}, {3'b000, eerr});
    endtask

    // Rotating column scan with random strobe lengths until the press ends.
    task automatic scan(input int max_scans, input bit glitch, input bit noise);
        logic [2:0] c;
        int         per;
        for (int s = 0; s < max_scans && m_act; s++) begin
            for (int ci = 0; ci < 3; ci++) begin
                c = 3'b111;
                c[ci] = 1'b0;
                if (glitch && $urandom_range(0, 4) == 0) c = 3'($urandom_range(0, 7));
                per = $urandom_range(3, 8);
                for (int p = 0; p < per; p++)
                    cyc(c, noise && m_act && ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
            end
        end
        n_cmp++;
        assert (!m_act) else begin
            n_bad++;
            $error("FAIL press_bound: still pressing after %0d scans, expected done", max_scans);
        end
    endtask

    initial begin
        rst = 1'b1; column = 3'b111; key_code = 4'h0; req_a = 1'b0; req_b = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_row_a", row_a, 4'hF);
        check("rst_busy_a", {3'b000, busy_a}, 4'h0);
        check("rst_done_a", {3'b000, done_a}, 4'h0);
        check("rst_err_a", {3'b000, err_a}, 4'h0);
        check("rst_row_b", row_b, 4'hF);
        rst = 1'b0;

        sel = 0;
        cyc(3'b111, 1'b1, 4'h5);
        scan(20, 1'b0, 1'b0);

        sel = 1;
        cyc(3'b111, 1'b1, KEY_HASH);
        scan(30, 1'b0, 1'b1);

        sel = 0;
        cyc(3'b111, 1'b1, 4'hC);
        cyc(3'b111, 1'b0, 4'h0);
        cyc(3'b111, 1'b0, 4'h0);

        cyc(3'b111, 1'b1, 4'h1);
        for (int i = 0; i < 70000 && m_act; i++) cyc(3'b111, 1'b0, 4'h0);
        n_cmp++;
        assert (!m_act) else begin
            n_bad++;
            $error("FAIL timeout_bound: still pressing, expected abort");
        end
        cyc(3'b111, 1'b0, 4'h0);

        cyc(3'b111, 1'b1, 4'h0);
        for (int i = 0; i < 6; i++) cyc(3'b100, 1'b0, 4'h0);
        scan(30, 1'b1, 1'b0);

        cyc(3'b111, 1'b1, 4'h0);
        for (int i = 0; i < 4; i++) cyc(3'b110, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) cyc(3'b101, 1'b0, 4'h0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_row", row_a, 4'hF);
        check("rst_mid_busy", {3'b000, busy_a}, 4'h0);
        check("rst_mid_done", {3'b000, done_a}, 4'h0);
        column = 3'b111;
        @(posedge clk); #1;
        rst = 1'b0;
        m_act = 1'b0; m_s1 = 3'b111; m_s2 = 3'b111;
        cyc(3'b111, 1'b1, 4'h7);
        scan(20, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            sel = int'($urandom_range(0, 1));
            cyc(3'b111, 1'b1, 4'($urandom_range(0, 15)));
            scan(40, 1'($urandom_range(0, 1)), 1'b1);
            cyc(3'b111, 1'b0, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Drives a 3-column x 4-row matrix keypad in place of the physical keys, for hardware self-test of the password lock.
- It sits on the scanner side of the keypad pins: it samples the column strobes the scanner drives and answers on the row lines as if a chosen key were pressed, bounced and released.
- A controller (test sequencer or debug switches) requests one key press at a time through a req/busy/done handshake.

Parameters:
- HOLD_SCANS, 4, number of complete scans of the key's column during which the key reads as pressed (1..15)
- BOUNCE_SCANS, 0, number of leading scans of the key's column during which the key alternates pressed/open, pressed on even-indexed scans (0..15)
- RELEASE_SCANS, 2, number of scans of the key's column with all rows open before done (1..15)
- TIMEOUT_CYC, 65535, clk cycles without a falling edge on the key's column before the press is aborted (16-bit counter)

Ports:
- clk  input  1  system clock, same clock that drives the keypad scanner
- rst  input  1  asynchronous reset, active-high
- key_code  input  4  key to press: 0-9 digits, 4'hA = '*', 4'hB = '#'
- press_req  input  1  single-cycle request; key_code is sampled in the same cycle
- column  input  3  scanner column strobes, active-low one-hot; bit0 = left column
- row  output  4  row returns, active-low, bit0 = top row; 4'b1111 = no key
- busy  output  1  high from the cycle after an accepted request until done or err
- done  output  1  one-cycle pulse when the release phase completes
- err  output  1  one-cycle pulse on an invalid key_code or a timeout

Behaviour:
- Key map (row, col):
  - row0: 1, 2, 3
  - row1: 4, 5, 6
  - row2: 7, 8, 9
  - row3: *, 0, #
- Reset values: row = 4'b1111, busy = 0, done = 0, err = 0, FSM = IDLE, all counters 0.
- Row path:
  - row is registered, 1-clk latency from column.
  - row[r] = 0 only when all of these hold: the FSM is in PRESS (or in BOUNCE on a pressed scan), column equals exactly the latched key's one-hot-low pattern, and r is the key's row.
  - Any other column value (all-high, multiple low, other column) gives 4'b1111.
- Scan event: a falling edge of the latched key's column bit, with column sampled into a register and the previous value kept. One event per scan.
- FSM states: IDLE, BOUNCE, PRESS, RELEASE.
  - IDLE:
    - press_req with key_code <= 4'hB: latch code, clear counters, go to BOUNCE (or straight to PRESS when BOUNCE_SCANS = 0); busy = 1 from the next cycle.
    - press_req with key_code > 4'hB: err pulse next cycle, stay in IDLE, busy stays 0.
  - BOUNCE: count scan events; the key reads pressed when the count is even. After BOUNCE_SCANS events, go to PRESS.
  - PRESS: key reads pressed; after HOLD_SCANS events, go to RELEASE.
  - RELEASE: rows all open; after RELEASE_SCANS events, done = 1 for one cycle, busy = 0 in the same cycle, go to IDLE.
- State change timing: the transition on the Nth event takes effect in the same cycle the event is detected, so the row drive changes on the following clk.
- Timeout:
  - In any non-IDLE state, a watchdog counter increments every clk and clears on each scan event.
  - When the counter reaches TIMEOUT_CYC: err pulse, busy = 0, row = 4'b1111, FSM = IDLE.
- press_req while busy: ignored; no err, latched code unchanged.
- done and err never assert in the same cycle.
- Reset mid-press: row returns to 4'b1111 immediately (asynchronously); no done pulse.
- Counters are 4-bit and saturate; a parameter value of 0 is legal only for BOUNCE_SCANS.

Decomposition:
- Shared package keypad_pkg:
  - key code constants: KEY_STAR = 4'hA, KEY_HASH = 4'hB, KEY_NONE = 4'hF
  - the code-to-(row, col) decode function
  - the FSM state encoding
- One sub-module, keypad_key_decode: combinational, key_code -> 3-bit one-hot-low column pattern, 4-bit one-hot-low row pattern, and a valid flag.
- FSM, counters and watchdog stay in keypad_emulator.

Test Plan:
- Request key 4'h5, scanner rotating column 110 -> 101 -> 011 every 8 clk, defaults -> row = 1101 only while column = 101, for 4 scans; then 2 open scans; done pulse; busy is high for the whole press.
- Request key 4'hB ('#') with BOUNCE_SCANS = 3 -> row3 low on column 011 during bounce scans 0 and 2, open on scan 1, then 4 solid scans, then done.
- Request key 4'hC -> err pulse 1 clk later, busy stays 0, row stays 1111.
- Request key 4'h1, then hold column at 111 -> after 65535 clk, err pulse, busy = 0, row = 1111.
- Drive column = 100 (two lines low) during a '0' press -> row = 1111 for those cycles; the press completes normally afterwards.
- Assert rst mid-PRESS of key 4'h0 -> row = 1111 immediately and busy = 0; no done pulse; a new request after reset completes normally.
